// File: rtl/game_pkg.sv
// Shared definitions for the game bookkeeping blocks.
//   - game_state encodings driven by game_controller
//   - default point values per event kind
//   - player life state machine encoding
package game_pkg;

    localparam logic [2:0] GS_START = 3'd1;
    localparam logic [2:0] GS_PLAY  = 3'd2;
    localparam logic [2:0] GS_WIN   = 3'd3;
    localparam logic [2:0] GS_OVER  = 3'd4;

    localparam logic [9:0] GOLD_POINTS   = 10'd500;
    localparam logic [9:0] ALIEN_POINTS  = 10'd250;
    localparam logic [9:0] DIMOND_POINTS = 10'd25;

    // Largest score representable in four BCD digits.
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ALIVE,
        DEAD_WAIT,
        OUT
    } life_state_t;

endpackage

// File: rtl/bcd_add_sat4.sv
// Combinational 4-digit BCD adder with saturation at 9999.
// Ports:
//   i_bcd  [15:0]  augend, four packed BCD digits, [15:12] thousands
//   i_add  [9:0]   binary addend (0..1023)
//   o_sum  [15:0]  BCD sum, clamped to 16'h9999 on overflow
module bcd_add_sat4 (
    input  logic [15:0] i_bcd,
    input  logic [9:0]  i_add,
    output logic [15:0] o_sum
);

    logic [3:0]  w_add_dig [4];
    logic [15:0] w_sum;
    logic [4:0]  w_dsum;
    logic        w_carry;

    // Split the binary addend into decimal digits (constant divisors only).
    always_comb begin
        w_add_dig[0] = 4'(i_add % 10'd10);
        w_add_dig[1] = 4'((i_add / 10'd10) % 10'd10);
        w_add_dig[2] = 4'((i_add / 10'd100) % 10'd10);
        w_add_dig[3] = 4'(i_add / 10'd1000);
    end

    // Ripple the decimal carry from units to thousands; a carry out of the
    // thousands digit means the true sum exceeded 9999.
    always_comb begin
        w_sum   = 16'h0000;
        w_carry = 1'b0;
        w_dsum  = 5'd0;
        for (int i = 0; i < 4; i++) begin
            w_dsum = 5'(i_bcd[4*i +: 4]) + 5'(w_add_dig[i]) + 5'(w_carry);
            if (w_dsum > 5'd9) begin
                w_sum[4*i +: 4] = 4'(w_dsum - 5'd10);
                w_carry         = 1'b1;
            end else begin
                w_sum[4*i +: 4] = w_dsum[3:0];
                w_carry         = 1'b0;
            end
        end
        o_sum = w_carry ? 16'h9999 : w_sum;
    end

endmodule

// File: rtl/lives_score_keeper.sv
// Game bookkeeping beside game_controller: folds per-pixel collision strobes
// into at most one event of each kind per frame, commits them on startOfFrame,
// and keeps the BCD score, bonus life, lives count and respawn timing.
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   startOfFrame         one-cycle pulse per frame; commit point
//   game_state [2:0]     1 start, 2 play, 3 win, 4 over
//   restart_gameN        sync active-low: reload lives, back to ALIVE
//   reset_scoreN         sync active-low: clear score and bonus flag
//   player_died, player_eat_gold_1, alien_died_a, dimond_eaten   event strobes
//   score_bcd [15:0]     four BCD digits, [15:12] thousands
//   lives [2:0]          remaining lives
//   player_awake         high only while ALIVE
//   no_lives_left        high only while OUT
module lives_score_keeper
    import game_pkg::*;
#(
    parameter logic [2:0]  INIT_LIVES       = 3'd3,
    parameter logic [2:0]  MAX_LIVES        = 3'd5,
    parameter logic [7:0]  RESPAWN_FRAMES   = 8'd60,
    parameter logic [9:0]  PTS_GOLD         = GOLD_POINTS,
    parameter logic [9:0]  PTS_ALIEN        = ALIEN_POINTS,
    parameter logic [9:0]  PTS_DIMOND       = DIMOND_POINTS,
    parameter logic [13:0] EXTRA_LIFE_SCORE = 14'd5000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [2:0]  game_state,
    input  logic        restart_gameN,
    input  logic        reset_scoreN,
    input  logic        player_died,
    input  logic        player_eat_gold_1,
    input  logic        alien_died_a,
    input  logic        dimond_eaten,
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic        player_awake,
    output logic        no_lives_left
);

    function automatic logic [13:0] sat_score(input logic [14:0] s);
        return (s > 15'(SCORE_MAX)) ? SCORE_MAX : s[13:0];
    endfunction

    function automatic logic [2:0] sat_lives_inc(input logic [2:0] l);
        return (l >= MAX_LIVES) ? MAX_LIVES : l + 3'd1;
    endfunction

    logic        r_die, r_gold, r_alien, r_dimond;
    logic [13:0] r_score_bin;
    logic [15:0] r_score_bcd;
    logic        r_bonus_given;
    logic [2:0]  r_lives;
    logic [7:0]  r_frame_cnt;
    life_state_t r_state;

    logic [9:0]  w_add;
    logic [13:0] w_score_bin_nxt;
    logic [15:0] w_score_bcd_nxt;
    logic        w_bonus_hit;
    logic [2:0]  w_lives_bonus;
    life_state_t w_state_nxt;
    logic [2:0]  w_lives_nxt;
    logic [7:0]  w_frame_cnt_nxt;

    // ---- Event folding: one flag per kind, reloaded on each frame boundary ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_die    <= 1'b0;
            r_gold   <= 1'b0;
            r_alien  <= 1'b0;
            r_dimond <= 1'b0;
        end else if (!restart_gameN || game_state != GS_PLAY) begin
            r_die    <= 1'b0;
            r_gold   <= 1'b0;
            r_alien  <= 1'b0;
            r_dimond <= 1'b0;
        end else if (startOfFrame) begin
            // A strobe coincident with the boundary belongs to the next frame.
            r_die    <= player_died;
            r_gold   <= player_eat_gold_1;
            r_alien  <= alien_died_a;
            r_dimond <= dimond_eaten;
        end else begin
            r_die    <= r_die    | player_died;
            r_gold   <= r_gold   | player_eat_gold_1;
            r_alien  <= r_alien  | alien_died_a;
            r_dimond <= r_dimond | dimond_eaten;
        end
    end

    // ---- Commit: score add, then bonus life ----
    assign w_add = (r_gold   ? PTS_GOLD   : 10'd0)
                 + (r_alien  ? PTS_ALIEN  : 10'd0)
                 + (r_dimond ? PTS_DIMOND : 10'd0);

    assign w_score_bin_nxt = sat_score(15'(r_score_bin) + 15'(w_add));

    bcd_add_sat4 u_bcd_add (
        .i_bcd (r_score_bcd),
        .i_add (w_add),
        .o_sum (w_score_bcd_nxt)
    );

    // A held score reset suppresses the commit, so no bonus can be earned then.
    assign w_bonus_hit   = startOfFrame && reset_scoreN && !r_bonus_given
                         && (w_score_bin_nxt >= EXTRA_LIFE_SCORE);
    assign w_lives_bonus = w_bonus_hit ? sat_lives_inc(r_lives) : r_lives;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_score_bin   <= 14'd0;
            r_score_bcd   <= 16'h0000;
            r_bonus_given <= 1'b0;
        end else if (!reset_scoreN) begin
            r_score_bin   <= 14'd0;
            r_score_bcd   <= 16'h0000;
            r_bonus_given <= 1'b0;
        end else if (startOfFrame) begin
            r_score_bin <= w_score_bin_nxt;
            r_score_bcd <= w_score_bcd_nxt;
            if (w_bonus_hit) begin
                r_bonus_given <= 1'b1;
            end
        end
    end

    // ---- Life FSM: death is applied to the post-bonus lives value ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ALIVE;
            r_lives     <= INIT_LIVES;
            r_frame_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_frame_cnt_nxt = r_frame_cnt;
        if (startOfFrame) begin
            w_lives_nxt = w_lives_bonus;
            case (r_state)
                ALIVE: begin
                    if (r_die) begin
                        if (w_lives_bonus > 3'd1) begin
                            w_lives_nxt     = w_lives_bonus - 3'd1;
                            w_state_nxt     = DEAD_WAIT;
                            w_frame_cnt_nxt = 8'd0;
                        end else begin
                            // Last life gone (or already none): never underflow.
                            w_lives_nxt = 3'd0;
                            w_state_nxt = OUT;
                        end
                    end
                end
                DEAD_WAIT: begin
                    if (r_frame_cnt == RESPAWN_FRAMES - 8'd1) begin
                        w_state_nxt = ALIVE;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
                OUT: begin
                    w_state_nxt = OUT;
                end
                default: begin
                    w_state_nxt = ALIVE;
                end
            endcase
        end
        if (!restart_gameN) begin
            w_state_nxt     = ALIVE;
            w_lives_nxt     = INIT_LIVES;
            w_frame_cnt_nxt = 8'd0;
        end
    end

    assign score_bcd     = r_score_bcd;
    assign lives         = r_lives;
    assign player_awake  = (r_state == ALIVE);
    assign no_lives_left = (r_state == OUT);

endmodule

// File: tb/tb_lives_score_keeper.sv
module tb_lives_score_keeper;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [2:0]  game_state;
    logic        restart_gameN;
    logic        reset_scoreN;
    logic        player_died;
    logic        player_eat_gold_1;
    logic        alien_died_a;
    logic        dimond_eaten;
    logic [15:0] score_bcd;
    logic [2:0]  lives;
    logic        player_awake;
    logic        no_lives_left;

    always #5 clk = ~clk;

    lives_score_keeper dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .game_state        (game_state),
        .restart_gameN     (restart_gameN),
        .reset_scoreN      (reset_scoreN),
        .player_died       (player_died),
        .player_eat_gold_1 (player_eat_gold_1),
        .alien_died_a      (alien_died_a),
        .dimond_eaten      (dimond_eaten),
        .score_bcd         (score_bcd),
        .lives             (lives),
        .player_awake      (player_awake),
        .no_lives_left     (no_lives_left)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain integers describing the game bookkeeping.
    int m_score;      // binary score
    bit m_bonus;      // bonus life already granted this score run
    int m_lives;
    int m_mode;       // 0 playing, 1 asleep after a death, 2 out of lives
    int m_sleep;      // frames left before waking
    bit ev_die, ev_gold, ev_alien, ev_dim;  // events seen in the current frame

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_score = 0; m_bonus = 0; m_lives = 3; m_mode = 0; m_sleep = 0;
        ev_die = 0; ev_gold = 0; ev_alien = 0; ev_dim = 0;
    endtask

    // One clock edge with the inputs currently applied.
    task automatic model_step();
        int add;
        int ns;
        if (!resetN) begin
            model_reset();
            return;
        end
        if (startOfFrame) begin
            if (reset_scoreN) begin
                add = (ev_gold ? 500 : 0) + (ev_alien ? 250 : 0) + (ev_dim ? 25 : 0);
                ns  = m_score + add;
                if (ns > 9999) ns = 9999;
                if (ns >= 5000 && !m_bonus) begin
                    m_bonus = 1;
                    if (m_lives < 5) m_lives++;
                end
                m_score = ns;
            end
            if (m_mode == 0 && ev_die) begin
                if (m_lives > 0) m_lives--;
                if (m_lives == 0) m_mode = 2;
                else begin
                    m_mode  = 1;
                    m_sleep = 60;
                end
            end else if (m_mode == 1) begin
                m_sleep--;
                if (m_sleep == 0) m_mode = 0;
            end
        end
        if (!reset_scoreN) begin
            m_score = 0;
            m_bonus = 0;
        end
        if (!restart_gameN) begin
            m_lives = 3;
            m_mode  = 0;
        end
        if (!restart_gameN || game_state != 3'd2) begin
            ev_die = 0; ev_gold = 0; ev_alien = 0; ev_dim = 0;
        end else if (startOfFrame) begin
            ev_die = player_died; ev_gold = player_eat_gold_1;
            ev_alien = alien_died_a; ev_dim = dimond_eaten;
        end else begin
            ev_die   = ev_die   | player_died;
            ev_gold  = ev_gold  | player_eat_gold_1;
            ev_alien = ev_alien | alien_died_a;
            ev_dim   = ev_dim   | dimond_eaten;
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check16("score", score_bcd, to_bcd(m_score));
        check16("lives", {13'd0, lives}, 16'(m_lives));
        check16("awake", {15'd0, player_awake}, {15'd0, m_mode == 0});
        check16("no_lives", {15'd0, no_lives_left}, {15'd0, m_mode == 2});
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
    endtask

    task automatic strobe(input bit d, input bit g, input bit a, input bit m);
        player_died = d; player_eat_gold_1 = g; alien_died_a = a; dimond_eaten = m;
        cyc();
        player_died = 0; player_eat_gold_1 = 0; alien_died_a = 0; dimond_eaten = 0;
    endtask

    task automatic frame(input bit d, input bit g, input bit a, input bit m);
        strobe(d, g, a, m);
        pulse_sof();
    endtask

    task automatic wait_frames(input int n);
        repeat (n) frame(0, 0, 0, 0);
    endtask

    task automatic clear_score();
        reset_scoreN = 1'b0;
        cyc();
        reset_scoreN = 1'b1;
    endtask

    task automatic restart();
        restart_gameN = 1'b0;
        cyc();
        restart_gameN = 1'b1;
    endtask

    initial begin
        resetN = 0; startOfFrame = 0; game_state = 3'd2;
        restart_gameN = 1; reset_scoreN = 1;
        player_died = 0; player_eat_gold_1 = 0; alien_died_a = 0; dimond_eaten = 0;
        model_reset();
        cyc(); cyc();
        resetN = 1;
        cyc();

        // T1 reset values
        check16("t1_score", score_bcd, 16'h0000);
        check16("t1_lives", {13'd0, lives}, 16'd3);
        check16("t1_awake", {15'd0, player_awake}, 16'd1);
        check16("t1_nll", {15'd0, no_lives_left}, 16'd0);

        // T2 folding: many gold strobes in one frame count once
        player_eat_gold_1 = 1;
        repeat (200) cyc();
        player_eat_gold_1 = 0;
        pulse_sof();
        check16("t2_gold_once", score_bcd, 16'h0500);
        clear_score();
        strobe(0, 1, 0, 0); strobe(0, 0, 1, 0); strobe(0, 0, 0, 1);
        pulse_sof();
        check16("t2_all_three", score_bcd, 16'h0775);

        // T3 death and respawn
        frame(1, 0, 0, 0);
        check16("t3_lives", {13'd0, lives}, 16'd2);
        check16("t3_asleep", {15'd0, player_awake}, 16'd0);
        for (int i = 1; i <= 59; i++) frame(i == 30, 0, 0, 0);
        check16("t3_still_asleep", {15'd0, player_awake}, 16'd0);
        frame(0, 0, 0, 0);
        check16("t3_awake", {15'd0, player_awake}, 16'd1);
        check16("t3_lives_kept", {13'd0, lives}, 16'd2);

        // T4 game over and restart
        frame(1, 0, 0, 0);
        wait_frames(60);
        frame(1, 0, 0, 0);
        check16("t4_lives0", {13'd0, lives}, 16'd0);
        check16("t4_nll", {15'd0, no_lives_left}, 16'd1);
        wait_frames(3);
        check16("t4_out_holds", {15'd0, no_lives_left}, 16'd1);
        restart();
        check16("t4_restart_lives", {13'd0, lives}, 16'd3);
        check16("t4_restart_nll", {15'd0, no_lives_left}, 16'd0);
        check16("t4_restart_awake", {15'd0, player_awake}, 16'd1);

        // T5 bonus and saturation
        clear_score();
        repeat (9) frame(0, 1, 0, 0);
        frame(0, 0, 1, 0);
        check16("t5_preload", score_bcd, 16'h4750);
        frame(0, 0, 1, 0);
        check16("t5_5000", score_bcd, 16'h5000);
        check16("t5_bonus", {13'd0, lives}, 16'd4);
        repeat (9) frame(0, 1, 0, 0);
        frame(0, 0, 1, 0);
        repeat (6) frame(0, 0, 0, 1);
        check16("t5_9900", score_bcd, 16'h9900);
        check16("t5_no_second_bonus", {13'd0, lives}, 16'd4);
        frame(0, 1, 0, 0);
        check16("t5_sat", score_bcd, 16'h9999);
        frame(0, 1, 1, 1);
        check16("t5_sat_hold", score_bcd, 16'h9999);
        clear_score();
        repeat (10) frame(0, 1, 0, 0);
        check16("t5_to5", {13'd0, lives}, 16'd5);
        clear_score();
        repeat (10) frame(0, 1, 0, 0);
        check16("t5_cap5", {13'd0, lives}, 16'd5);

        // Score and death in the same commit: bonus first, then the death
        restart();
        frame(1, 0, 0, 0); wait_frames(60);
        frame(1, 0, 0, 0); wait_frames(60);
        check16("t5_one_life", {13'd0, lives}, 16'd1);
        clear_score();
        repeat (9) frame(0, 1, 0, 0);
        frame(0, 0, 1, 0);
        frame(1, 0, 1, 0);
        check16("t5_sim_score", score_bcd, 16'h5000);
        check16("t5_sim_lives", {13'd0, lives}, 16'd1);
        check16("t5_sim_nll", {15'd0, no_lives_left}, 16'd0);
        check16("t5_sim_asleep", {15'd0, player_awake}, 16'd0);
        wait_frames(60);
        check16("t5_sim_awake", {15'd0, player_awake}, 16'd1);

        // T6 gating and edges
        clear_score();
        game_state = 3'd1;
        strobe(1, 1, 1, 1); strobe(0, 1, 0, 0);
        pulse_sof();
        check16("t6_gated_score", score_bcd, 16'h0000);
        check16("t6_gated_lives", {13'd0, lives}, 16'd1);
        game_state = 3'd2;
        cyc();
        startOfFrame = 1; player_eat_gold_1 = 1;
        cyc();
        startOfFrame = 0; player_eat_gold_1 = 0;
        check16("t6_sof_strobe_deferred", score_bcd, 16'h0000);
        pulse_sof();
        check16("t6_sof_strobe_next", score_bcd, 16'h0500);
        restart();
        frame(1, 0, 0, 0);
        wait_frames(5);
        check16("t6_dead_wait", {15'd0, player_awake}, 16'd0);
        @(posedge clk); #1;
        model_step_noclock_reset();
        #1;
        check16("t6_rst_score", score_bcd, 16'h0000);
        check16("t6_rst_lives", {13'd0, lives}, 16'd3);
        check16("t6_rst_awake", {15'd0, player_awake}, 16'd1);
        check16("t6_rst_nll", {15'd0, no_lives_left}, 16'd0);
        cyc(); cyc();
        resetN = 1;
        cyc();

        // Randomized phase against the model
        for (int c = 0; c < 4000; c++) begin
            game_state        = ($urandom_range(0, 9) < 8) ? 3'd2 : 3'($urandom_range(1, 4));
            startOfFrame      = ($urandom_range(0, 7) == 0);
            player_died       = ($urandom_range(0, 19) == 0);
            player_eat_gold_1 = ($urandom_range(0, 5) == 0);
            alien_died_a      = ($urandom_range(0, 5) == 0);
            dimond_eaten      = ($urandom_range(0, 5) == 0);
            restart_gameN     = !($urandom_range(0, 399) == 0);
            reset_scoreN      = !($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 1999) == 0) begin
                resetN = 0;
                model_reset();
            end else begin
                resetN = 1;
            end
            cyc();
        end
        resetN = 1; startOfFrame = 0; restart_gameN = 1; reset_scoreN = 1;
        player_died = 0; player_eat_gold_1 = 0; alien_died_a = 0; dimond_eaten = 0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Asynchronous reset applied between clock edges.
    task automatic model_step_noclock_reset();
        resetN = 0;
        model_reset();
    endtask

endmodule
